// File: rtl/lsu_mem_port.sv
// Load/store initiator for the byte-addressed mem_block port: one outstanding access, sized writes, extended loads.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests return an error response without touching memory.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int SIZE       = 8,
  parameter int WB_W       = $clog2(DATA_WIDTH/SIZE)+1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [WB_W-1:0]       mem_write_bits_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [1:0]            dbg_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload never change while waiting for ready.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                r_state, w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_sign;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_accept = req_valid_i && (r_state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [ADDR_WIDTH-1:0] w_align_mask;
  assign w_align_mask = (ADDR_WIDTH'(1) << req_size_i) - ADDR_WIDTH'(1);
  assign w_misalign   = (req_addr_i & w_align_mask) != '0;
`else
  assign w_misalign = 1'b0;
`endif

  // Keep the low 2^size bytes of the read word, fill the rest with the sign or zeros.
  always_comb begin
    w_sign = 1'b0;
    case (r_size)
      2'd0:    w_sign = mem_data_i[SIZE-1];
      2'd1:    w_sign = mem_data_i[2*SIZE-1];
      2'd2:    w_sign = mem_data_i[4*SIZE-1];
      default: w_sign = mem_data_i[8*SIZE-1];
    endcase
    w_sign = w_sign && !r_uns;
    w_ext  = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      w_ext[i] = (i < (SIZE << r_size)) ? mem_data_i[i] : w_sign;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_misalign ? RESP : ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (resp_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we_i;
      r_size  <= req_size_i;
      r_uns   <= req_unsigned_i;
      r_addr  <= req_addr_i;
      r_wdata <= req_wdata_i;
      r_rdata <= '0;
      r_err   <= w_misalign;
    end else if (r_state == ACCESS) begin
      r_rdata <= r_we ? '0 : w_ext;
    end
  end

  // Write enable comes straight from the state register, so a store still commits if reset lands mid-access.
  always_comb begin
    req_ready_o      = 1'b0;
    resp_valid_o     = 1'b0;
    mem_write_bits_o = '0;
    case (r_state)
      IDLE:    req_ready_o = 1'b1;
      ACCESS:  if (r_we) mem_write_bits_o = WB_W'(1) << r_size;
      RESP:    resp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;
  assign mem_addr_o   = r_addr;
  assign mem_data_o   = r_wdata;
  assign dbg_state_o  = r_state;
endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator that drives the byte-addressed `mem_block` port from the core's memory pipeline stage. It accepts one load or store request per transaction over a valid/ready handshake and converts the access size into the memory's byte-count write enable. It captures the memory's combinational read data and returns a sign- or zero-extended result over a second valid/ready handshake. There is one outstanding transaction at a time.

## Interface
- `ADDR_WIDTH`, 32, byte address width; must match the attached `mem_block`.
- `DATA_WIDTH`, 64, data path width in bits.
- `SIZE`, 8, bits per addressable unit.
- `WB_W`, `$clog2(DATA_WIDTH/SIZE)+1`, width of the byte-count write enable.

- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
- `req_unsigned_i`  in  1  load zero-extends when 1; ignored for stores.
- `req_addr_i`  in  ADDR_WIDTH  byte address.
- `req_wdata_i`  in  DATA_WIDTH  store data, right-aligned (byte 0 = bits [7:0]).
- `resp_valid_o`  out  1  response present.
- `resp_ready_i`  in  1  consumer accepts the response.
- `resp_rdata_o`  out  DATA_WIDTH  extended load data; 0 for stores.
- `resp_err_o`  out  1  misalignment fault (see Configuration).
- `mem_addr_o`  out  ADDR_WIDTH  to `mem_block.addr_i`.
- `mem_data_o`  out  DATA_WIDTH  to `mem_block.data_i`.
- `mem_write_bits_o`  out  WB_W  to `mem_block.write_bits_i`; number of bytes written.
- `mem_data_i`  in  DATA_WIDTH  from `mem_block.data_o`; combinational read.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i && req_ready_o`, the block latches `we`, `size`, `unsigned`, `addr` and `wdata`, then moves to ACCESS.
- **ACCESS** (exactly one cycle)
  - `mem_addr_o` = latched addr.
  - `mem_data_o` = latched wdata, unshifted.
  - `mem_write_bits_o` = 1 << size for stores, 0 for loads.
  - At the closing edge, for a load the block captures `mem_data_i` bytes [0 .. 2^size-1].
    - Signed load: sign-extend from bit 8·2^size−1.
    - Unsigned load: zero-extend.
    - Size 3 loads: no extension.
  - Moves to RESP.
- **RESP**
  - `resp_valid_o`=1; `resp_rdata_o` and `resp_err_o` are held stable.
  - On `resp_ready_i`, the block returns to IDLE.
  - No new request is accepted in the same cycle; `req_ready_o`=0 outside IDLE.
- Memory drive outside ACCESS:
  - `mem_write_bits_o`=0.
  - `mem_addr_o` and `mem_data_o` hold their last latched values.
- Addresses wrap modulo 2^ADDR_WIDTH; the block performs no bounds checking.
- `mem_write_bits_o` is decoded from the state register. A store therefore commits at the ACCESS closing edge even if `rst_i` is high in that cycle; that transaction's response is discarded.
- Reset values: state=IDLE, `req_ready_o`=1, `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0, `mem_write_bits_o`=0, `mem_addr_o`=0, `mem_data_o`=0.

## Timing
- Request accepted at edge E0. ACCESS runs in cycle E0→E1. `resp_valid_o` is high from E1 onward.
- Minimum request-to-request spacing is 3 cycles, reached when `resp_ready_i` is held high.
- `resp_valid_o` stays high and outputs stay stable until the handshake completes. Backpressure of any length is allowed.
- The `req_*` inputs are sampled only at the accepting edge; later changes are ignored.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined**
  - An access is misaligned when addr mod 2^size ≠ 0.
  - A misaligned request skips ACCESS and goes from IDLE straight to RESP.
  - In that response `resp_err_o`=1 and `resp_rdata_o`=0.
  - `mem_write_bits_o` stays 0, so no store commits.
  - Fault responses have 1-cycle latency.
- **Undefined**
  - Misaligned accesses proceed normally; `mem_block` handles arbitrary byte addresses.
  - `resp_err_o` is tied to 0.

## Test plan
- Reset then idle → `req_ready_o`=1, `resp_valid_o`=0, `mem_write_bits_o`=0.
- SD addr 0x100, wdata 0x8877665544332211 → `mem_write_bits_o`=8 for exactly one cycle. A following LD of 0x100 returns 0x8877665544332211, with `resp_valid_o` 2 cycles after acceptance.
- After the previous store, LB at 0x107 returns 0xFFFFFFFFFFFFFF88. LBU at 0x107 returns 0x88. LH at 0x106 returns 0xFFFFFFFFFFFF8877. LWU at 0x104 returns 0x88776655.
- SB 0xAA to 0x101, then LD 0x100 → 0x887766554433AA11; only one byte changes.
- Hold `resp_ready_i`=0 for 5 cycles → `resp_valid_o` and `resp_rdata_o` stay stable and `req_ready_o` stays 0. A new `req_valid_i` during the stall is not accepted.
- With `LSU_MISALIGN_TRAP_EN`: SW to 0x102 → `resp_err_o`=1 one cycle after acceptance, and a later LD 0x100 shows memory unchanged. Without the macro: the same SW writes 4 bytes starting at 0x102 and `resp_err_o`=0.
